// File: rtl/seq_gen_1010.sv
// Serial 1010 pattern transmitter: shifts a programmable pattern MSB-first for a
// programmed number of passes and flags every bit that completes an overlapping "1010".
module seq_gen_1010 #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] pat_len_i,
    input  logic [CNT_W-1:0] rep_cnt_i,
    output logic             data_out_o,
    output logic             data_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             exp_match_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd2;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [1:0]       trk_q, trk_d;

    logic [PAT_W-1:0] pat_sh;
    logic             start_ok;
    logic             valid;
    logic             bit_cur;

    assign start_ok = start_i && (pat_len_i != '0) && (pat_len_i <= PAT_W_L) &&
                      (rep_cnt_i != '0);

    // Shift instead of a variable index keeps the LEN_W-wide index width-clean.
    assign pat_sh  = pat_q >> idx_q;
    assign valid   = (state_q == S_SHIFT);
    assign bit_cur = valid & pat_sh[0];

    assign data_valid_o = valid;
    assign data_out_o   = bit_cur;
    assign busy_o       = valid;
    assign done_o       = (state_q == S_FIN);
    assign exp_match_o  = valid && (trk_q == T3) && !bit_cur;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        trk_d   = trk_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    pat_d   = pattern_i;
                    len_d   = pat_len_i;
                    rep_d   = rep_cnt_i;
                    idx_d   = pat_len_i - LEN_W'(1);
                    trk_d   = T0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (idx_q == '0) begin
                    if (rep_q != CNT_W'(1)) begin
                        rep_d = rep_q - CNT_W'(1);
                        idx_d = len_q - LEN_W'(1);
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    idx_d = idx_q - LEN_W'(1);
                end
                // Tracker runs across pass boundaries so overlaps there are seen.
                case (trk_q)
                    T0:      trk_d = bit_cur ? T1 : T0;
                    T1:      trk_d = bit_cur ? T1 : T2;
                    T2:      trk_d = bit_cur ? T3 : T0;
                    default: trk_d = bit_cur ? T1 : T2;
                endcase
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            trk_q   <= T0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            trk_q   <= trk_d;
        end
    end

endmodule

// File: tb/tb_seq_gen_1010.sv
// Scoreboard bench for seq_gen_1010: expected per-cycle output tuples are queued when
// a transfer is started and compared on the falling edge while the DUT runs.
module tb_seq_gen_1010;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic [7:0] pattern_i;
    logic [3:0] pat_len_i;
    logic [3:0] rep_cnt_i;
    logic       data_out_o, data_valid_o, busy_o, done_o, exp_match_o;

    int vectors = 0;
    int miscompares = 0;

    // tuple: {valid, data, match, busy, done}
    logic [4:0] exp_q[$];

    seq_gen_1010 #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .pattern_i   (pattern_i),
        .pat_len_i   (pat_len_i),
        .rep_cnt_i   (rep_cnt_i),
        .data_out_o  (data_out_o),
        .data_valid_o(data_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .exp_match_o (exp_match_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [4:0] observed();
        return {data_valid_o, data_out_o, exp_match_o, busy_o, done_o};
    endfunction

    // Reference stream: "1010" completes whenever the last four sent bits are 1010.
    task automatic push_xfer(input logic [7:0] pat, input int len, input int rep);
        logic [3:0] hist = 4'b0;
        int         n = 0;
        logic       b, m;
        for (int p = 0; p < rep; p++) begin
            for (int i = len - 1; i >= 0; i--) begin
                b    = pat[i];
                hist = {hist[2:0], b};
                n++;
                m    = (n >= 4) && (hist == 4'b1010);
                exp_q.push_back({1'b1, b, m, 1'b1, 1'b0});
            end
        end
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
    endtask

    task automatic push_idle(input int cycles);
        for (int i = 0; i < cycles; i++) exp_q.push_back(5'b00000);
    endtask

    task automatic start_xfer(input logic [7:0] pat, input logic [3:0] len,
                              input logic [3:0] rep);
        @(negedge clk_i);
        pattern_i = pat;
        pat_len_i = len;
        rep_cnt_i = rep;
        start_i   = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // poke=1 re-pulses start and scrambles the inputs while bits are going out.
    task automatic drain(input string nm, input bit poke);
        logic [4:0] exp_v, act;
        int n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk_i);
            exp_v = exp_q.pop_front();
            act   = observed();
            vectors++;
            if (act !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got {v,d,m,busy,done}=%b expected %b",
                         nm, n, act, exp_v);
            end
            if (poke && n == 2) begin
                start_i   = 1'b1;
                pattern_i = ~pattern_i;
                pat_len_i = 4'd3;
                rep_cnt_i = 4'd1;
            end else if (poke && n == 3) begin
                start_i = 1'b0;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        vectors++;
        if (observed() !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 00000", observed());
        end
        rst_ni = 1'b1;
        push_idle(3);
        drain("idle_after_reset", 1'b0);
    endtask

    task automatic test_alt8();
        start_xfer(8'b10101010, 4'd8, 4'd1);
        push_xfer(8'b10101010, 8, 1);
        drain("alt8", 1'b0);
    endtask

    task automatic test_back_to_back();
        start_xfer(8'b00001010, 4'd4, 4'd3);
        push_xfer(8'b00001010, 4, 3);
        drain("rep3", 1'b0);
    endtask

    task automatic test_t3_on_one();
        start_xfer(8'b00010110, 4'd5, 4'd2);
        push_xfer(8'b00010110, 5, 2);
        drain("t3_on_one", 1'b0);
    endtask

    task automatic test_illegal();
        start_xfer(8'hAA, 4'd0, 4'd2);
        push_idle(4);
        drain("len0", 1'b0);
        start_xfer(8'hAA, 4'd4, 4'd0);
        push_idle(4);
        drain("rep0", 1'b0);
        start_xfer(8'hAA, 4'd9, 4'd1);
        push_idle(4);
        drain("len9", 1'b0);
        start_xfer(8'b00000110, 4'd3, 4'd2);
        push_xfer(8'b00000110, 3, 2);
        drain("legal_after_illegal", 1'b0);
    endtask

    task automatic test_mid_change();
        start_xfer(8'b11010010, 4'd8, 4'd2);
        push_xfer(8'b11010010, 8, 2);
        drain("mid_change", 1'b1);
    endtask

    task automatic test_reset_abort();
        logic [4:0] exp_v;
        start_xfer(8'b10100101, 4'd8, 4'd1);
        push_xfer(8'b10100101, 8, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            exp_v = exp_q.pop_front();
            vectors++;
            if (observed() !== exp_v) begin
                miscompares++;
                $display("FAIL abort_prefix bit %0d: got %b expected %b", i, observed(), exp_v);
            end
        end
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if (observed() !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected 00000", observed());
        end
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        push_idle(3);
        drain("no_done_after_abort", 1'b0);
        start_xfer(8'b01011010, 4'd8, 4'd1);
        push_xfer(8'b01011010, 8, 1);
        drain("fresh_after_abort", 1'b0);
    endtask

    initial begin
        rst_ni    = 1'b0;
        start_i   = 1'b0;
        pattern_i = '0;
        pat_len_i = '0;
        rep_cnt_i = '0;
        test_reset();
        test_alt8();
        test_back_to_back();
        test_t3_on_one();
        test_illegal();
        test_mid_change();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
